// File: rtl/multu_hilo_if.sv
// Handshake and result bundle between the instruction decoder and the HI/LO multiplier.
// The decoder side is the master; the multiplier is the slave.
interface multu_hilo_if #(parameter int WIDTH = 32);
    logic             start;
    logic             readreq;
    logic [WIDTH-1:0] srca;
    logic [WIDTH-1:0] srcb;
    logic [WIDTH-1:0] hi;
    logic [WIDTH-1:0] lo;
    logic             busy;
    logic             done;
    logic             stall;

    modport master (
        output start, readreq, srca, srcb,
        input  hi, lo, busy, done, stall
    );

    modport slave (
        input  start, readreq, srca, srcb,
        output hi, lo, busy, done, stall
    );
endinterface

// File: rtl/multu_hilo_unit.sv
// Iterative shift-add unsigned multiplier that owns the architectural HI/LO registers.
// One operand bit per cycle; results commit to hi/lo only when the last iteration retires.
module multu_hilo_unit #(
    parameter int WIDTH = 32
) (
    input  logic          clk,
    input  logic          reset,
    multu_hilo_if.slave   bus
);
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplr;
    logic [WIDTH:0]   acc;
    logic [CW-1:0]    count;
    logic [WIDTH-1:0] hi_q;
    logic [WIDTH-1:0] lo_q;
    logic             busy_q;
    logic             done_q;

    logic [WIDTH:0]   sum;
    logic [2*WIDTH:0] shifted;
    logic             last;

    // acc's carry bit is always cleared by the shift, so adding the full acc equals adding its low half.
    always_comb begin
        sum     = acc + {1'b0, (mplr[0] ? mcand : {WIDTH{1'b0}})};
        shifted = {sum, mplr} >> 1;
        last    = (count == CW'(WIDTH - 1));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            mcand  <= '0;
            mplr   <= '0;
            acc    <= '0;
            count  <= '0;
            hi_q   <= '0;
            lo_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        mcand  <= bus.srca;
                        mplr   <= bus.srcb;
                        acc    <= '0;
                        count  <= '0;
                        busy_q <= 1'b1;
                        state  <= RUN;
                    end
                end
                RUN: begin
                    acc   <= shifted[2*WIDTH:WIDTH];
                    mplr  <= shifted[WIDTH-1:0];
                    count <= count + 1'b1;
                    if (last) begin
                        hi_q   <= shifted[2*WIDTH-1:WIDTH];
                        lo_q   <= shifted[WIDTH-1:0];
                        busy_q <= 1'b0;
                        done_q <= 1'b1;
                        state  <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.hi    = hi_q;
    assign bus.lo    = lo_q;
    assign bus.busy  = busy_q;
    assign bus.done  = done_q;
    assign bus.stall = busy_q & (bus.start | bus.readreq);
endmodule

// File: tb/tb_multu_hilo_unit.sv
// Self-checking bench for multu_hilo_unit: a cycle-level product model checked every cycle,
// directed scenarios with literal expectations, then a randomized start/readreq/reset mix.
module tb_multu_hilo_unit;
    localparam int WIDTH = 32;

    logic clk;
    logic reset;
    bit   checking;
    int   errors;
    int   checks;

    multu_hilo_if #(.WIDTH(WIDTH)) bus ();

    multu_hilo_unit #(.WIDTH(WIDTH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a product is captured on accept and appears WIDTH edges later.
    logic [2*WIDTH-1:0] m_prod;
    logic [WIDTH-1:0]   m_hi;
    logic [WIDTH-1:0]   m_lo;
    int                 m_left;
    logic               m_done;

    initial begin
        m_prod = '0; m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
    end

    always @(posedge clk) begin
        if (reset) begin
            m_hi = '0; m_lo = '0; m_left = 0; m_done = 1'b0;
        end else begin
            m_done = 1'b0;
            if (m_left > 0) begin
                m_left = m_left - 1;
                if (m_left == 0) begin
                    {m_hi, m_lo} = m_prod;
                    m_done = 1'b1;
                end
            end else if (bus.start) begin
                m_prod = {{WIDTH{1'b0}}, bus.srca} * {{WIDTH{1'b0}}, bus.srcb};
                m_left = WIDTH;
            end
        end
    end

    task automatic checkOutput(input string name, input logic [WIDTH-1:0] act,
                               input logic [WIDTH-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic applyStimulus(input logic st, input logic rd,
                                 input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        bus.start   = st;
        bus.readreq = rd;
        bus.srca    = a;
        bus.srcb    = b;
    endtask

    always @(negedge clk) begin
        if (checking) begin
            checkOutput("cyc_hi",    bus.hi, m_hi);
            checkOutput("cyc_lo",    bus.lo, m_lo);
            checkOutput("cyc_busy",  {31'b0, bus.busy},  {31'b0, (m_left > 0)});
            checkOutput("cyc_done",  {31'b0, bus.done},  {31'b0, m_done});
            checkOutput("cyc_stall", {31'b0, bus.stall},
                        {31'b0, (m_left > 0) && (bus.start || bus.readreq)});
        end
    end

    // Starts one multiply, keeps readreq at rd during RUN, scrambles operands after accept.
    task automatic runMul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic rd,
                          output int busyCyc, output int doneCyc,
                          output logic [WIDTH-1:0] midHi, output logic [WIDTH-1:0] midLo,
                          output logic midStall);
        @(posedge clk); #1 applyStimulus(1'b1, rd, a, b);
        @(posedge clk); #1 applyStimulus(1'b0, rd, $urandom, $urandom);
        busyCyc = 0; doneCyc = 0; midHi = '0; midLo = '0; midStall = 1'b0;
        for (int i = 0; i < 36; i++) begin
            @(negedge clk);
            if (bus.busy) busyCyc++;
            if (bus.done) doneCyc++;
            if (i == 15) begin
                midHi = bus.hi; midLo = bus.lo; midStall = bus.stall;
            end
        end
        @(posedge clk); #1 applyStimulus(1'b0, 1'b0, '0, '0);
    endtask

    int               busyCyc;
    int               doneCyc;
    logic [WIDTH-1:0] midHi;
    logic [WIDTH-1:0] midLo;
    logic             midStall;

    initial begin
        errors = 0; checks = 0; checking = 1'b0;
        reset = 1'b1;
        applyStimulus(1'b0, 1'b0, '0, '0);

        // Reset held two cycles, then idle with no stimulus.
        @(posedge clk); #1 checking = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        repeat (4) @(posedge clk);

        $display("[TB] basic 3x5");
        runMul(32'd3, 32'd5, 1'b0, busyCyc, doneCyc, midHi, midLo, midStall);
        checkOutput("t2_busy_cycles", busyCyc, 32'd32);
        checkOutput("t2_done_cycles", doneCyc, 32'd1);
        checkOutput("t2_hi", bus.hi, 32'h0000_0000);
        checkOutput("t2_lo", bus.lo, 32'h0000_000F);

        $display("[TB] boundary operands");
        runMul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, busyCyc, doneCyc, midHi, midLo, midStall);
        checkOutput("t3_max_hi", bus.hi, 32'hFFFF_FFFE);
        checkOutput("t3_max_lo", bus.lo, 32'h0000_0001);
        runMul(32'h0001_0000, 32'h0001_0000, 1'b0, busyCyc, doneCyc, midHi, midLo, midStall);
        checkOutput("t3_pow_hi", bus.hi, 32'h0000_0001);
        checkOutput("t3_pow_lo", bus.lo, 32'h0000_0000);

        $display("[TB] readreq during RUN");
        runMul(32'd3, 32'd5, 1'b0, busyCyc, doneCyc, midHi, midLo, midStall);
        runMul(32'd7, 32'd6, 1'b1, busyCyc, doneCyc, midHi, midLo, midStall);
        checkOutput("t4_mid_hi", midHi, 32'd0);
        checkOutput("t4_mid_lo", midLo, 32'd15);
        checkOutput("t4_mid_stall", {31'b0, midStall}, 32'd1);
        checkOutput("t4_busy_cycles", busyCyc, 32'd32);
        checkOutput("t4_hi", bus.hi, 32'd0);
        checkOutput("t4_lo", bus.lo, 32'd42);
        #1 applyStimulus(1'b0, 1'b1, '0, '0);
        @(negedge clk);
        checkOutput("t4_idle_stall", {31'b0, bus.stall}, 32'd0);
        @(posedge clk); #1 applyStimulus(1'b0, 1'b0, '0, '0);

        $display("[TB] reset mid-RUN");
        @(posedge clk); #1 applyStimulus(1'b1, 1'b0, 32'd9, 32'd9);
        @(posedge clk); #1 applyStimulus(1'b0, 1'b0, '0, '0);
        repeat (9) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("t5_busy", {31'b0, bus.busy}, 32'd0);
        checkOutput("t5_hi", bus.hi, 32'd0);
        checkOutput("t5_lo", bus.lo, 32'd0);
        doneCyc = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) doneCyc++;
        end
        checkOutput("t5_no_done", doneCyc, 32'd0);
        runMul(32'd2, 32'd21, 1'b0, busyCyc, doneCyc, midHi, midLo, midStall);
        checkOutput("t5_lo", bus.lo, 32'd42);

        $display("[TB] start held across two operations");
        @(posedge clk); #1 applyStimulus(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000);
        @(posedge clk); #1 applyStimulus(1'b1, 1'b0, 32'd4, 32'd4);
        doneCyc = 0; midStall = 1'b0;
        for (int i = 0; i < 33; i++) begin
            @(negedge clk);
            if (bus.done) doneCyc++;
            if (i == 5) midStall = bus.stall;
            @(posedge clk);
        end
        #1 applyStimulus(1'b0, 1'b0, '0, '0);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (bus.done) doneCyc++;
        end
        checkOutput("t6_stall", {31'b0, midStall}, 32'd1);
        checkOutput("t6_done_pulses", doneCyc, 32'd2);
        checkOutput("t6_hi", bus.hi, 32'd0);
        checkOutput("t6_lo", bus.lo, 32'd16);

        $display("[TB] randomized traffic");
        for (int i = 0; i < 1500; i++) begin
            @(posedge clk);
            #1;
            applyStimulus(($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                          $urandom, $urandom);
            reset = ($urandom_range(0, 299) == 0);
        end
        @(posedge clk); #1 reset = 1'b0; applyStimulus(1'b0, 1'b0, '0, '0);
        repeat (40) @(posedge clk);
        @(negedge clk);
        checking = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
